// File: rtl/button_reader_pkg.sv
// Shared definitions for the button input chain: debounce FSM state encodings and sync depth.
package button_reader_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// Flop-chain synchroniser for one asynchronous input; reset loads RESET_VAL into every stage.
module sync_2ff
    import button_reader_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/button_reader.sv
// Push-button conditioner: synchroniser, polarity fix, debounce FSM, long-press and optional
// auto-repeat strobes (auto-repeat built only when BUTTON_READER_REPEAT_EN is defined).
module button_reader
    import button_reader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int LONG_CYCLES     = 12000000,
    parameter int REPEAT_CYCLES   = 1200000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HCNT_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HCNT_LONG = HW'(LONG_CYCLES - 1);

    logic sync;
    logic s;

    sync_2ff #(
        .RESET_VAL(ACTIVE_LOW)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (btn_in),
        .q  (sync)
    );

    assign s = sync ^ ACTIVE_LOW;

    btn_state_e    state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d, hcnt_inc;
    logic          long_done_q, long_done_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          holding;

    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        hcnt_d      = hcnt_q;
        long_done_d = long_done_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        holding     = (state_q == HELD) || (state_q == RELEASE_WAIT);
        hcnt_inc    = (hcnt_q == HCNT_MAX) ? hcnt_q : hcnt_q + 1'b1;

        case (state_q)
            RELEASED: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    dcnt_d  = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = RELEASED;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d     = HELD;
                    press_d     = 1'b1;
                    level_d     = 1'b1;
                    hcnt_d      = '0;
                    long_done_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            HELD: begin
                hcnt_d = hcnt_inc;
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    dcnt_d  = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d = HELD;
                    hcnt_d  = hcnt_inc;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d   = RELEASED;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                    hcnt_d = hcnt_inc;
                end
            end
            default: state_d = RELEASED;
        endcase

        // An accepted release on the threshold cycle swallows the long-press strobe.
        if (holding && !long_done_q && (hcnt_q == HCNT_LONG) && !release_d) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RELEASED;
            dcnt_q      <= '0;
            hcnt_q      <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            hcnt_q      <= hcnt_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    assign btn_level     = level_q;
    assign press         = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;

`ifdef BUTTON_READER_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] RCNT_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          repeat_q, repeat_d;

    always_comb begin
        rcnt_d   = rcnt_q;
        repeat_d = 1'b0;
        if (long_d) begin
            rcnt_d = '0;
        end else if (holding && long_done_q) begin
            if (rcnt_q == RCNT_LAST) begin
                repeat_d = 1'b1;
                rcnt_d   = '0;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end
        if (state_d == RELEASED) begin
            rcnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt_q   <= '0;
            repeat_q <= 1'b0;
        end else begin
            rcnt_q   <= rcnt_d;
            repeat_q <= repeat_d;
        end
    end

    assign repeat_pulse = repeat_q;
`else
    logic repeat_cfg_unused;
    assign repeat_cfg_unused = ^32'(REPEAT_CYCLES);
    assign repeat_pulse      = 1'b0;
`endif

endmodule

// File: tb/tb_button_reader.sv
// Bench for button_reader: directed test-plan steps plus random pin activity, both polarities,
// checked every cycle against a run-length debounce model.
module tb_button_reader;

    localparam int D = 4;
    localparam int L = 20;
    localparam int R = 5;
`ifdef BUTTON_READER_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic btn;
    logic btn_n;
    assign btn_n = ~btn;

    logic hi_level, hi_press, hi_rel, hi_long, hi_rep;
    logic lo_level, lo_press, lo_rel, lo_long, lo_rep;

    button_reader #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R), .ACTIVE_LOW(1'b0)) u_hi (
        .clk(clk), .rst(rst), .btn_in(btn), .btn_level(hi_level), .press(hi_press),
        .release_pulse(hi_rel), .long_press(hi_long), .repeat_pulse(hi_rep));

    button_reader #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R), .ACTIVE_LOW(1'b1)) u_lo (
        .clk(clk), .rst(rst), .btn_in(btn_n), .btn_level(lo_level), .press(lo_press),
        .release_pulse(lo_rel), .long_press(lo_long), .repeat_pulse(lo_rep));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: pressed-ness s(t) is the pin two edges late; a change is accepted
    // after D+1 consecutive samples disagreeing with the accepted level.
    bit m_sh1, m_sh2, m_level, m_fired;
    int m_run, m_age, m_since;
    bit e_press, e_rel, e_long, e_rep;

    // Observed history of the active-high instance for the directed checks.
    int n_press, n_rel, n_long, n_rep;
    int press_cyc, rel_cyc, long_cyc, first_rep_cyc;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit s, was_pressed, accept;
        e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0; e_rep = 1'b0;
        if (rst) begin
            m_sh1 = 1'b0; m_sh2 = 1'b0; m_level = 1'b0; m_fired = 1'b0;
            m_run = 0; m_age = 0; m_since = 0;
            return;
        end
        s           = m_sh2;
        was_pressed = m_level;
        m_run       = (s != m_level) ? m_run + 1 : 0;
        accept      = (m_run == D + 1);
        if (was_pressed) begin
            m_age++;
            if (REP_EN && m_fired) begin
                m_since++;
                if (m_since == R) begin
                    e_rep   = 1'b1;
                    m_since = 0;
                end
            end
            if (!m_fired && m_age == L && !accept) begin
                e_long  = 1'b1;
                m_fired = 1'b1;
                m_since = 0;
            end
        end
        if (accept) begin
            m_level = ~m_level;
            m_run   = 0;
            if (m_level) begin
                e_press = 1'b1;
                m_age   = 0;
                m_fired = 1'b0;
            end else begin
                e_rel = 1'b1;
            end
        end
        m_sh2 = m_sh1;
        m_sh1 = btn;
    endtask

    task automatic check_all();
        chk("hi_level", hi_level, m_level);
        chk("hi_press", hi_press, e_press);
        chk("hi_release", hi_rel, e_rel);
        chk("hi_long", hi_long, e_long);
        chk("hi_repeat", hi_rep, e_rep);
        chk("lo_level", lo_level, m_level);
        chk("lo_press", lo_press, e_press);
        chk("lo_release", lo_rel, e_rel);
        chk("lo_long", lo_long, e_long);
        chk("lo_repeat", lo_rep, e_rep);
        if (hi_press) begin n_press++; press_cyc = cyc; end
        if (hi_rel)   begin n_rel++;   rel_cyc   = cyc; end
        if (hi_long)  begin n_long++;  long_cyc  = cyc; end
        if (hi_rep) begin
            if (n_rep == 0) first_rep_cyc = cyc;
            n_rep++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        check_all();
    endtask

    task automatic clear_hist();
        n_press = 0; n_rel = 0; n_long = 0; n_rep = 0;
        press_cyc = -1; rel_cyc = -1; long_cyc = -1; first_rep_cyc = -1;
    endtask

    initial begin
        int t0;
        int r0;
        int len;
        int stop_at;

        btn = 1'b0;
        rst = 1'b1;
        clear_hist();
        repeat (3) tick();
        chk("reset_level", hi_level, 1'b0);
        chk("reset_press", hi_press, 1'b0);
        rst = 1'b0;
        repeat (4) tick();

        // Clean press
        clear_hist();
        btn = 1'b1;
        t0  = cyc + 1;
        repeat (12) tick();
        chk_int("clean_press_count", n_press, 1);
        chk_int("clean_press_cycle", press_cyc, t0 + 6);
        chk_int("clean_press_no_release", n_rel, 0);
        chk_int("clean_press_no_long", n_long, 0);
        chk("clean_press_level", hi_level, 1'b1);

        // Release glitch, then clean release
        btn = 1'b0;
        repeat (3) tick();
        btn = 1'b1;
        repeat (2) tick();
        chk_int("glitch_single_press", n_press, 1);
        chk_int("glitch_no_release", n_rel, 0);
        chk("glitch_level", hi_level, 1'b1);
        btn = 1'b0;
        t0  = cyc + 1;
        repeat (12) tick();
        chk_int("clean_release_count", n_rel, 1);
        chk_int("clean_release_cycle", rel_cyc, t0 + 6);
        chk_int("clean_release_no_long", n_long, 0);
        chk("clean_release_level", hi_level, 1'b0);

        // Bounce
        clear_hist();
        for (int i = 0; i < 8; i++) begin
            btn = (i % 2 == 0) ? 1'b1 : 1'b0;
            repeat (2) tick();
        end
        chk_int("bounce_no_strobe", n_press + n_rel, 0);
        btn = 1'b1;
        t0  = cyc + 1;
        repeat (12) tick();
        chk_int("bounce_press_count", n_press, 1);
        chk_int("bounce_press_cycle", press_cyc, t0 + 6);
        btn = 1'b0;
        repeat (12) tick();

        // Long press
        clear_hist();
        btn = 1'b1;
        repeat (7 + 40) tick();
        chk_int("long_count", n_long, 1);
        chk_int("long_cycle", long_cyc, press_cyc + 20);
        chk_int("long_first_repeat", first_rep_cyc, REP_EN ? long_cyc + 5 : -1);
        chk_int("long_repeat_count", n_rep, REP_EN ? 4 : 0);
        btn = 1'b0;
        repeat (12) tick();

        // Reset mid-hold
        btn = 1'b1;
        repeat (10) tick();
        chk("midhold_level_before_rst", hi_level, 1'b1);
        clear_hist();
        rst = 1'b1;
        tick();
        r0 = cyc;
        chk("midhold_rst_level", hi_level, 1'b0);
        chk("midhold_rst_release", hi_rel, 1'b0);
        chk("midhold_rst_lo_level", lo_level, 1'b0);
        rst = 1'b0;
        repeat (10) tick();
        chk_int("midhold_no_release", n_rel, 0);
        chk_int("midhold_press_count", n_press, 1);
        chk_int("midhold_press_cycle", press_cyc, r0 + 7);
        btn = 1'b0;
        repeat (12) tick();

        // Random pin activity with occasional resets
        stop_at = cyc + 2000;
        while (cyc < stop_at) begin
            btn = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 45) : $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                rst = ($urandom_range(0, 59) == 0);
                tick();
            end
            rst = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
